// File: rtl/rvfi_consistency_monitor_if.sv
// RVFI retirement bundle (NRET=1) as seen by a stream consumer.
// Latency: none, wires only.
// Backpressure: none; RVFI is a pure observation stream with no ready.
// Ports: rvfi_valid strobe plus order, trap/intr, rs1/rs2/rd, pc and memory-mask fields.
interface rvfi_consistency_monitor_if;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [4:0]  rvfi_rs1_addr;
    logic [4:0]  rvfi_rs2_addr;
    logic [31:0] rvfi_rs1_rdata;
    logic [31:0] rvfi_rs2_rdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_trap, rvfi_intr,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_mem_rmask, rvfi_mem_wmask
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_trap, rvfi_intr,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_mem_rmask, rvfi_mem_wmask
    );
endinterface

// File: rtl/rvfi_consistency_monitor.sv
// Shadow-regfile consistency monitor for the RVFI retirement stream; captures the first error.
// Latency: one cycle from rvfi_valid to err_*/counters/shadow_valid_o.
// Backpressure: none; accepts one retirement every cycle, never stalls the core.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync clear), rvfi (slave modport),
//        err_o / err_code_o / err_order_o (first error), err_cnt_o, retired_cnt_o, shadow_valid_o.
module rvfi_consistency_monitor #(
    parameter bit          CheckPcChain = 1'b1,
    parameter int unsigned ErrCntW      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    rvfi_consistency_monitor_if.slave     rvfi,
    output logic                          err_o,
    output logic [2:0]                    err_code_o,
    output logic [63:0]                   err_order_o,
    output logic [ErrCntW-1:0]            err_cnt_o,
    output logic [31:0]                   retired_cnt_o,
    output logic [31:0]                   shadow_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic [31:0] shadow_q [32];
    logic [31:0] valid_q;
    logic [63:0] prev_order_q;
    logic [31:0] prev_pc_wdata_q;
    logic        prev_trap_q;

    logic        err_q;
    logic [2:0]  err_code_q;
    logic [63:0] err_order_q;
    logic [ErrCntW-1:0] err_cnt_q;
    logic [31:0] retired_cnt_q;

    logic        order_bad, rs1_bad, rs2_bad, rd_bad, pc_bad, trap_bad, mem_bad;
    logic [2:0]  code;
    logic        err_now;
    logic        accept;
    logic        rd_update;

    // A retirement coinciding with clear_i is discarded entirely.
    assign accept    = rvfi.rvfi_valid && !clear_i;
    assign rd_update = accept && !rvfi.rvfi_trap && (rvfi.rvfi_rd_addr != 5'd0);

    // All checks look at registered state only, so a same-retirement
    // read/write of one register compares against the pre-update value.
    always_comb begin
        order_bad = (state_q == IDLE) ? (rvfi.rvfi_order != 64'd0)
                                      : (rvfi.rvfi_order != prev_order_q + 64'd1);

        if (rvfi.rvfi_rs1_addr == 5'd0) begin
            rs1_bad = (rvfi.rvfi_rs1_rdata != 32'd0);
        end else begin
            rs1_bad = valid_q[rvfi.rvfi_rs1_addr] &&
                      (rvfi.rvfi_rs1_rdata != shadow_q[rvfi.rvfi_rs1_addr]);
        end

        if (rvfi.rvfi_rs2_addr == 5'd0) begin
            rs2_bad = (rvfi.rvfi_rs2_rdata != 32'd0);
        end else begin
            rs2_bad = valid_q[rvfi.rvfi_rs2_addr] &&
                      (rvfi.rvfi_rs2_rdata != shadow_q[rvfi.rvfi_rs2_addr]);
        end

        rd_bad   = (rvfi.rvfi_rd_addr == 5'd0) && (rvfi.rvfi_rd_wdata != 32'd0);

        // Trap entry legitimately breaks the chain: skip after a trap and on
        // the first handler instruction.
        pc_bad   = CheckPcChain && (state_q != IDLE) && !rvfi.rvfi_intr && !prev_trap_q &&
                   (rvfi.rvfi_pc_rdata != prev_pc_wdata_q);

        trap_bad = rvfi.rvfi_trap && (rvfi.rvfi_rd_addr != 5'd0);
        mem_bad  = (rvfi.rvfi_mem_rmask != 4'd0) && (rvfi.rvfi_mem_wmask != 4'd0);

        // Lowest code wins.
        if (order_bad)     code = 3'd1;
        else if (rs1_bad)  code = 3'd2;
        else if (rs2_bad)  code = 3'd3;
        else if (rd_bad)   code = 3'd4;
        else if (pc_bad)   code = 3'd5;
        else if (trap_bad) code = 3'd6;
        else if (mem_bad)  code = 3'd7;
        else               code = 3'd0;

        err_now = accept && (code != 3'd0);
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else if (rvfi.rvfi_valid) begin
            unique case (state_q)
                IDLE:    state_d = err_now ? ERR : RUN;
                RUN:     state_d = err_now ? ERR : RUN;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
            valid_q         <= '0;
            prev_order_q    <= '0;
            prev_pc_wdata_q <= '0;
            prev_trap_q     <= 1'b0;
            err_q           <= 1'b0;
            err_code_q      <= '0;
            err_order_q     <= '0;
            err_cnt_q       <= '0;
            retired_cnt_q   <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
            valid_q         <= '0;
            prev_order_q    <= '0;
            prev_pc_wdata_q <= '0;
            prev_trap_q     <= 1'b0;
            err_q           <= 1'b0;
            err_code_q      <= '0;
            err_order_q     <= '0;
            err_cnt_q       <= '0;
            retired_cnt_q   <= '0;
        end else if (accept) begin
            if (rd_update) begin
                shadow_q[rvfi.rvfi_rd_addr] <= rvfi.rvfi_rd_wdata;
                valid_q[rvfi.rvfi_rd_addr]  <= 1'b1;
            end
            // Always resync to the observed stream, even after an error.
            prev_order_q    <= rvfi.rvfi_order;
            prev_pc_wdata_q <= rvfi.rvfi_pc_wdata;
            prev_trap_q     <= rvfi.rvfi_trap;
            retired_cnt_q   <= retired_cnt_q + 32'd1;
            if (err_now) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_code_q  <= code;
                    err_order_q <= rvfi.rvfi_order;
                end
                if (err_cnt_q != {ErrCntW{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
        end
    end

    assign err_o          = err_q;
    assign err_code_o     = err_code_q;
    assign err_order_o    = err_order_q;
    assign err_cnt_o      = err_cnt_q;
    assign retired_cnt_o  = retired_cnt_q;
    assign shadow_valid_o = valid_q;

endmodule

// File: tb/tb_rvfi_consistency_monitor.sv
// Directed bench for rvfi_consistency_monitor with hand-computed expectations.
// Latency: checks sample outputs 1 time unit after the capturing edge.
// Backpressure: not applicable; one retirement is driven per fire.
module tb_rvfi_consistency_monitor;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        err_o;
    logic [2:0]  err_code_o;
    logic [63:0] err_order_o;
    logic [7:0]  err_cnt_o;
    logic [31:0] retired_cnt_o;
    logic [31:0] shadow_valid_o;

    int errors = 0;
    int checks = 0;

    rvfi_consistency_monitor_if rv();

    rvfi_consistency_monitor #(
        .CheckPcChain (1'b1),
        .ErrCntW      (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .rvfi           (rv.slave),
        .err_o          (err_o),
        .err_code_o     (err_code_o),
        .err_order_o    (err_order_o),
        .err_cnt_o      (err_cnt_o),
        .retired_cnt_o  (retired_cnt_o),
        .shadow_valid_o (shadow_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Zero every field of the retirement vector.
    task automatic vec_zero();
        rv.rvfi_valid     = 1'b0;
        rv.rvfi_order     = '0;
        rv.rvfi_trap      = 1'b0;
        rv.rvfi_intr      = 1'b0;
        rv.rvfi_rs1_addr  = '0;
        rv.rvfi_rs2_addr  = '0;
        rv.rvfi_rs1_rdata = '0;
        rv.rvfi_rs2_rdata = '0;
        rv.rvfi_rd_addr   = '0;
        rv.rvfi_rd_wdata  = '0;
        rv.rvfi_pc_rdata  = '0;
        rv.rvfi_pc_wdata  = '0;
        rv.rvfi_mem_rmask = '0;
        rv.rvfi_mem_wmask = '0;
    endtask

    task automatic fire();
        @(negedge clk_i);
        rv.rvfi_valid = 1'b1;
        @(posedge clk_i);
        #1;
        vec_zero();
    endtask

    task automatic do_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
    endtask

    initial begin
        vec_zero();
        #12;
        // Reset state.
        chk("rst_err", err_o, 0);
        chk("rst_code", err_code_o, 0);
        chk("rst_order", err_order_o, 0);
        chk("rst_cnt", err_cnt_o, 0);
        chk("rst_retired", retired_cnt_o, 0);
        chk("rst_shadow", shadow_valid_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Clean two-instruction stream.
        rv.rvfi_order = 0; rv.rvfi_rd_addr = 1; rv.rvfi_rd_wdata = 32'h5;
        rv.rvfi_pc_rdata = 32'h0; rv.rvfi_pc_wdata = 32'h4;
        fire();
        rv.rvfi_order = 1; rv.rvfi_rs1_addr = 1; rv.rvfi_rs1_rdata = 32'h5;
        rv.rvfi_pc_rdata = 32'h4; rv.rvfi_pc_wdata = 32'h8;
        fire();
        chk("clean_err", err_o, 0);
        chk("clean_retired", retired_cnt_o, 2);
        chk("clean_shadow", shadow_valid_o, 32'h2);

        // Order skip.
        do_clear();
        rv.rvfi_order = 0; rv.rvfi_rd_addr = 1; rv.rvfi_rd_wdata = 32'h5;
        rv.rvfi_pc_wdata = 32'h4;
        fire();
        rv.rvfi_order = 2; rv.rvfi_pc_rdata = 32'h4; rv.rvfi_pc_wdata = 32'h8;
        fire();
        chk("skip_err", err_o, 1);
        chk("skip_code", err_code_o, 1);
        chk("skip_order", err_order_o, 2);
        chk("skip_cnt", err_cnt_o, 1);
        rv.rvfi_order = 3; rv.rvfi_pc_rdata = 32'h8; rv.rvfi_pc_wdata = 32'hc;
        fire();
        chk("resync_cnt", err_cnt_o, 1);
        chk("resync_code", err_code_o, 1);
        chk("resync_retired", retired_cnt_o, 3);

        // clear_i together with an erroneous retirement: clear wins.
        @(negedge clk_i);
        clear_i = 1'b1;
        rv.rvfi_valid = 1'b1; rv.rvfi_order = 9; rv.rvfi_rd_addr = 4; rv.rvfi_rd_wdata = 32'h1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        vec_zero();
        chk("clr_err", err_o, 0);
        chk("clr_code", err_code_o, 0);
        chk("clr_order", err_order_o, 0);
        chk("clr_cnt", err_cnt_o, 0);
        chk("clr_retired", retired_cnt_o, 0);
        chk("clr_shadow", shadow_valid_o, 0);
        rv.rvfi_order = 0; rv.rvfi_rd_addr = 1; rv.rvfi_rd_wdata = 32'h5;
        rv.rvfi_pc_wdata = 32'h4;
        fire();
        chk("postclr_err", err_o, 0);
        chk("postclr_retired", retired_cnt_o, 1);

        // rs1 mismatch plus x0 write in one retirement: code 2 wins.
        rv.rvfi_order = 1; rv.rvfi_rs1_addr = 1; rv.rvfi_rs1_rdata = 32'h9;
        rv.rvfi_rd_addr = 0; rv.rvfi_rd_wdata = 32'h1;
        rv.rvfi_pc_rdata = 32'h4; rv.rvfi_pc_wdata = 32'h8;
        fire();
        chk("same_code", err_code_o, 2);
        chk("same_cnt", err_cnt_o, 1);
        chk("same_order", err_order_o, 1);
        chk("same_shadow", shadow_valid_o, 32'h2);

        // Read-then-write of the same register checks the old value.
        do_clear();
        rv.rvfi_order = 0; rv.rvfi_rd_addr = 2; rv.rvfi_rd_wdata = 32'h7;
        rv.rvfi_pc_wdata = 32'h4;
        fire();
        rv.rvfi_order = 1; rv.rvfi_rs1_addr = 2; rv.rvfi_rs1_rdata = 32'h7;
        rv.rvfi_rd_addr = 2; rv.rvfi_rd_wdata = 32'h8;
        rv.rvfi_pc_rdata = 32'h4; rv.rvfi_pc_wdata = 32'h8;
        fire();
        chk("rw_err", err_o, 0);
        // rs2 now reads stale 0x7 while shadow holds 0x8.
        rv.rvfi_order = 2; rv.rvfi_rs2_addr = 2; rv.rvfi_rs2_rdata = 32'h7;
        rv.rvfi_pc_rdata = 32'h8; rv.rvfi_pc_wdata = 32'hc;
        fire();
        chk("rs2_code", err_code_o, 3);
        chk("rs2_order", err_order_o, 2);

        // PC chain across a trap.
        do_clear();
        rv.rvfi_order = 0; rv.rvfi_pc_wdata = 32'h4;
        fire();
        rv.rvfi_order = 1; rv.rvfi_trap = 1; rv.rvfi_pc_rdata = 32'h4; rv.rvfi_pc_wdata = 32'h100;
        fire();
        rv.rvfi_order = 2; rv.rvfi_intr = 1; rv.rvfi_pc_rdata = 32'h80; rv.rvfi_pc_wdata = 32'h84;
        fire();
        chk("trap_chain_err", err_o, 0);
        rv.rvfi_order = 3; rv.rvfi_pc_rdata = 32'h90; rv.rvfi_pc_wdata = 32'h94;
        fire();
        chk("pc_code", err_code_o, 5);
        chk("pc_order", err_order_o, 3);

        // Trap with a destination register: code 6, no shadow write.
        do_clear();
        rv.rvfi_order = 0; rv.rvfi_trap = 1; rv.rvfi_rd_addr = 3; rv.rvfi_rd_wdata = 32'h1;
        fire();
        chk("trap_code", err_code_o, 6);
        chk("trap_shadow", shadow_valid_o, 0);

        // Load and store masks together: code 7.
        do_clear();
        rv.rvfi_order = 0; rv.rvfi_mem_rmask = 4'h1; rv.rvfi_mem_wmask = 4'h3;
        fire();
        chk("mem_code", err_code_o, 7);

        // Asynchronous reset mid-stream, then a non-zero order.
        do_clear();
        rv.rvfi_order = 0; rv.rvfi_rd_addr = 5; rv.rvfi_rd_wdata = 32'h3; rv.rvfi_pc_wdata = 32'h4;
        fire();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_retired", retired_cnt_o, 0);
        chk("arst_shadow", shadow_valid_o, 0);
        #1;
        rst_ni = 1'b1;
        rv.rvfi_order = 1; rv.rvfi_pc_rdata = 32'h4; rv.rvfi_pc_wdata = 32'h8;
        fire();
        chk("arst_code", err_code_o, 1);
        chk("arst_order", err_order_o, 1);

        // Saturation: 259 erroneous retirements, first one is code 1 at order 5.
        do_clear();
        rv.rvfi_order = 5;
        fire();
        for (int i = 1; i < 259; i++) begin
            rv.rvfi_order = 64'(5 + i);
            rv.rvfi_rd_addr = 0; rv.rvfi_rd_wdata = 32'h1;
            fire();
            if (i == 253) chk("sat_cnt_254", err_cnt_o, 8'hFE);
        end
        chk("sat_cnt", err_cnt_o, 8'hFF);
        chk("sat_code", err_code_o, 1);
        chk("sat_order", err_order_o, 5);
        chk("sat_retired", retired_cnt_o, 259);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvfi_consistency_monitor.md
Name: rvfi_consistency_monitor

Overview:
- Downstream consumer of the Ibex RVFI retirement stream (NRET=1); sits beside the riscv-formal checkers in the formal harness and in simulation.
- Keeps a shadow register file built from retired writebacks and checks stream-level consistency: order sequence, operand read-back, x0 rules, PC chaining, and trap/memory sanity.
- Captures the first error with its RVFI order, and keeps retirement and error counters for cover points and debug.

Parameters:
- CheckPcChain, 1, enable the PC-continuity check (0 = check disabled, never flagged).
- ErrCntW, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear of all state
- rvfi_valid  in  1  retirement strobe
- rvfi_order  in  64  retirement index
- rvfi_trap  in  1  instruction trapped
- rvfi_intr  in  1  first instruction of a trap handler
- rvfi_rs1_addr / rvfi_rs2_addr  in  5 each  source register indices
- rvfi_rs1_rdata / rvfi_rs2_rdata  in  32 each  source operand values
- rvfi_rd_addr  in  5  destination register index
- rvfi_rd_wdata  in  32  destination write value
- rvfi_pc_rdata / rvfi_pc_wdata  in  32 each  PC of this instruction / next PC
- rvfi_mem_rmask / rvfi_mem_wmask  in  4 each  memory byte masks
- err_o  out  1  sticky error flag
- err_code_o  out  3  code of the first error
- err_order_o  out  64  rvfi_order of the first error
- err_cnt_o  out  ErrCntW  count of erroneous retirements, saturating
- retired_cnt_o  out  32  retirement count, wraps
- shadow_valid_o  out  32  per-register "shadow holds a value" bits; bit 0 is always 0

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs are 0, the shadow file is 0, all valid bits are 0, and the FSM enters IDLE.
- FSM states:
  - IDLE: no retirement seen since reset or clear.
  - RUN: at least one retirement seen, no error.
  - ERR: first error captured.
- FSM transitions:
  - IDLE -> RUN on a clean retirement.
  - IDLE or RUN -> ERR on an erroneous retirement.
  - ERR is left only by reset or clear_i.
- Checks apply only when rvfi_valid=1, use registered state only, and complete in one cycle. Codes, with the lowest code winning when several fire:
  - 1: order. In IDLE the order must be 0; otherwise it must equal prev_order+1 (64-bit wrap).
  - 2: rs1. rs1_addr=0 requires rs1_rdata=0. Otherwise, if valid[rs1], rs1_rdata must equal shadow[rs1].
  - 3: rs2. Same rule as rs1, applied to rs2.
  - 4: rd. rd_addr=0 requires rd_wdata=0.
  - 5: pc. Applies when CheckPcChain=1, state is not IDLE, rvfi_intr=0 and prev_trap=0. pc_rdata must equal prev_pc_wdata.
  - 6: trap. rvfi_trap=1 with rd_addr!=0.
  - 7: mem. rmask!=0 and wmask!=0 on the same retirement.
- Update (same edge as check):
  - If rvfi_trap=0 and rd_addr!=0: shadow[rd] <= rd_wdata and valid[rd] <= 1.
  - A register read and written by the same retirement is checked against the pre-update value.
  - prev_order, prev_pc_wdata and prev_trap are always loaded from the current retirement, including after an error, so the checks resync to the observed stream.
- Error capture:
  - On the first error: err_o <= 1, and err_code_o / err_order_o are latched.
  - Later errors do not overwrite err_code_o or err_order_o.
  - err_cnt_o increments once per erroneous retirement and saturates at 2^ErrCntW-1.
- Latency: err_o and all counters reflect a retirement on the cycle after rvfi_valid.
- retired_cnt_o increments on every valid retirement and wraps 0xFFFFFFFF -> 0.
- clear_i has the same effect as reset, but synchronous. If clear_i and rvfi_valid are high together, clear wins and the retirement is discarded (not counted, not checked, no shadow update).
- Reset asserted mid-stream: state clears immediately. The next retirement after release must carry order 0, otherwise code 1 is flagged.
- Combinational-free outputs: every output is driven directly from a flop.

Test Plan:
- Directed stream:
  - Order 0: addi x1 with rd=1, wdata=0x5.
  - Order 1: rs1=1, rs1_rdata=0x5, pc_rdata = previous pc_wdata.
  - Required: err_o=0, retired_cnt_o=2, shadow_valid_o=0x2.
- Second retirement with order=2 instead of 1 -> err_o=1, err_code_o=1, err_order_o=2, err_cnt_o=1. A following retirement with order 3 is clean, and err_cnt_o stays 1.
- Same cycle:
  - Stimulus: rs1=1, rs1_rdata=0x9 (shadow holds 0x5), and rd=0 with wdata=0x1.
  - Required: err_code_o=2 (priority over code 4), and err_cnt_o increments by 1 only.
- PC chain:
  - Trap retirement: trap=1, rd=0, pc_wdata=0x100.
  - Next retirement: intr=1, pc_rdata=0x80.
  - Required: no error.
  - A later retirement with intr=0 and pc_rdata != prev pc_wdata -> err_code_o=5.
- clear_i asserted with rvfi_valid in the same cycle -> next cycle all outputs are 0 and the state is IDLE. A following retirement with order 0 is clean.
- Force 2^ErrCntW+3 errors -> err_cnt_o holds at 0xFF (ErrCntW=8) and err_code_o is unchanged from the first error.
